// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: register index width, data width, hardwired zero register.
package cpu_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     word_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/cpu_bank_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set at issue,
// cleared at writeback commit (set wins on a same-cycle collision). Bit 0 never sets.
module cpu_bank_reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [ADDR_WIDTH-1:0] read_reg_a,
  input  logic [ADDR_WIDTH-1:0] read_reg_b,
  output logic                  busy_a,
  output logic                  busy_b
);

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    sb_d[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      // A new producer issued in the same cycle as the old one commits stays outstanding.
      if (issue_valid && issue_reg == ADDR_WIDTH'(i)) begin
        sb_d[i] = 1'b1;
      end else if (write_enable && write_reg == ADDR_WIDTH'(i)) begin
        sb_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_comb begin
    busy_a = (read_reg_a == ADDR_WIDTH'(ZERO_REG)) ? 1'b0 : sb_q[read_reg_a];
    busy_b = (read_reg_b == ADDR_WIDTH'(ZERO_REG)) ? 1'b0 : sb_q[read_reg_b];
  end

endmodule

// File: rtl/cpu_bank_reg.sv
// Architectural register bank: one writeback port, two combinational read ports, busy scoreboard.
// Define CPU_BANK_REG_BYPASS_EN for same-cycle write-through on the read ports and busy flags.
module cpu_bank_reg
  import cpu_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg_a,
  input  logic [ADDR_WIDTH-1:0] read_reg_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  output logic                  busy_a,
  output logic                  busy_b
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  sb_busy_a;
  logic                  sb_busy_b;

  cpu_bank_reg_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .read_reg_a   (read_reg_a),
    .read_reg_b   (read_reg_b),
    .busy_a       (sb_busy_a),
    .busy_b       (sb_busy_b)
  );

  always_comb begin
    regs_d = regs_q;
    if (write_enable && write_reg != ADDR_WIDTH'(ZERO_REG)) begin
      regs_d[write_reg] = write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    read_data_a = (read_reg_a == ADDR_WIDTH'(ZERO_REG)) ? '0 : regs_q[read_reg_a];
    read_data_b = (read_reg_b == ADDR_WIDTH'(ZERO_REG)) ? '0 : regs_q[read_reg_b];
    busy_a      = sb_busy_a;
    busy_b      = sb_busy_b;
`ifdef CPU_BANK_REG_BYPASS_EN
    // Write-through is suppressed during reset so outputs read as zero while it is held.
    if (!reset && write_enable && write_reg == read_reg_a &&
        read_reg_a != ADDR_WIDTH'(ZERO_REG)) begin
      read_data_a = write_data;
      if (!(issue_valid && issue_reg == read_reg_a)) begin
        busy_a = 1'b0;
      end
    end
    if (!reset && write_enable && write_reg == read_reg_b &&
        read_reg_b != ADDR_WIDTH'(ZERO_REG)) begin
      read_data_b = write_data;
      if (!(issue_valid && issue_reg == read_reg_b)) begin
        busy_b = 1'b0;
      end
    end
`endif
  end

endmodule
